// File: rtl/popcount_scheduler_pkg.sv
// Shared widths, FSM state encoding and requester id type for the popcount scheduler.
package popcount_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/popcount_scheduler_rr_arb.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester not served last.
module popcount_rr_arb
  import popcount_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  req_id_t last_id;

  assign last_id = last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid0 && valid1) begin
        grant = (last_id == 1'b1) ? 2'b01 : 2'b10;
      end else begin
        grant = {valid1, valid0};
      end
    end
  end

endmodule

// File: rtl/popcount_scheduler.sv
// Time-shares one popcount unit between two valid/ready requesters and returns tagged counts.
// Optional self-check of unit_q with sticky err output: define POPCOUNT_SCHEDULER_CHECK_EN.
module popcount_scheduler
  import popcount_pkg::*;
#(
  parameter int DATA_W   = popcount_pkg::DATA_W,
  parameter int CNT_W    = popcount_pkg::CNT_W,
  parameter int UNIT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] unit_a,
  output logic              unit_load,
  input  logic [CNT_W-1:0]  unit_q,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_count,
  input  logic              resp_ready,
  output logic              busy
`ifdef POPCOUNT_SCHEDULER_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam logic [3:0] LAT_INIT = 4'(UNIT_LAT);

  sched_state_t state, next_state;
  req_id_t      cur_id;
  req_id_t      last_grant;
  logic [3:0]   wait_cnt;
  logic [1:0]   grant;
  logic         accept;
  logic         cnt_done;

  popcount_rr_arb u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign cnt_done   = (wait_cnt == 4'd1);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept)     next_state = LOAD;
      LOAD:                 next_state = WAIT;
      WAIT: if (cnt_done)   next_state = RESP;
      RESP: if (resp_ready) next_state = IDLE;
    endcase
  end

  // Operand, strobe and response registers; unit_a deliberately keeps its value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_a     <= '0;
      unit_load  <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_count <= '0;
      wait_cnt   <= 4'd0;
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unit_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unit_a    <= grant[1] ? req1_data : req0_data;
            cur_id    <= grant[1];
            unit_load <= 1'b1;
          end
        end
        LOAD: begin
          wait_cnt <= LAT_INIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (cnt_done) begin
            resp_count <= unit_q;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
          end
        end
      endcase
    end
  end

`ifdef POPCOUNT_SCHEDULER_CHECK_EN
  logic [CNT_W-1:0] local_cnt;

  always_comb begin
    local_cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      local_cnt = local_cnt + CNT_W'(unit_a[i]);
    end
  end

  // Sticky until reset so a single bad result from the unit is never missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == WAIT && cnt_done && local_cnt != unit_q) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_popcount_scheduler.sv
// Scoreboard bench for popcount_scheduler: LAT=1 instance under random traffic, LAT=3 instance for latency.
module tb_popcount_scheduler;
  import popcount_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct packed {
    logic       id;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_r0v, a_r1v, a_r0rdy, a_r1rdy, a_load, a_rv, a_rid, a_rrdy, a_busy;
  logic [7:0] a_r0d, a_r1d, a_ua;
  logic [3:0] a_q, a_rc;
  logic       b_r0v, b_r1v, b_r0rdy, b_r1rdy, b_load, b_rv, b_rid, b_rrdy, b_busy;
  logic [7:0] b_r0d, b_r1d, b_ua;
  logic [3:0] b_q, b_rc;
`ifdef POPCOUNT_SCHEDULER_CHECK_EN
  logic a_err, b_err;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t expq[$];
  exp_t monExp;
  logic lastServed = 1'b1;
  logic corrupt_f0 = 1'b0;

  popcount_scheduler #(.UNIT_LAT(LAT_A)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_r0v), .req0_data(a_r0d), .req0_ready(a_r0rdy),
    .req1_valid(a_r1v), .req1_data(a_r1d), .req1_ready(a_r1rdy),
    .unit_a(a_ua), .unit_load(a_load), .unit_q(a_q),
    .resp_valid(a_rv), .resp_id(a_rid), .resp_count(a_rc), .resp_ready(a_rrdy),
    .busy(a_busy)
`ifdef POPCOUNT_SCHEDULER_CHECK_EN
    , .err(a_err)
`endif
  );

  popcount_scheduler #(.UNIT_LAT(LAT_B)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0rdy),
    .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1rdy),
    .unit_a(b_ua), .unit_load(b_load), .unit_q(b_q),
    .resp_valid(b_rv), .resp_id(b_rid), .resp_count(b_rc), .resp_ready(b_rrdy),
    .busy(b_busy)
`ifdef POPCOUNT_SCHEDULER_CHECK_EN
    , .err(b_err)
`endif
  );

  function automatic logic [3:0] refPop(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return 4'(n);
  endfunction

  // Unit models: the count only becomes valid LAT cycles after the load cycle, garbage before that.
  logic [3:0] a_pend = 4'd0, b_pend = 4'd0;
  int         a_dly = 0, b_dly = 0;
  logic       a_qok = 1'b0, b_qok = 1'b0;

  always @(posedge clk) begin
    if (a_load) begin
      a_pend <= (corrupt_f0 && a_ua == 8'hF0) ? 4'd3 : refPop(a_ua);
      a_dly  <= LAT_A - 1;
      a_qok  <= (LAT_A == 1);
    end else if (a_dly > 0) begin
      a_dly <= a_dly - 1;
      a_qok <= (a_dly == 1);
    end
  end
  assign a_q = a_qok ? a_pend : ~a_pend;

  always @(posedge clk) begin
    if (b_load) begin
      b_pend <= refPop(b_ua);
      b_dly  <= LAT_B - 1;
      b_qok  <= (LAT_B == 1);
    end else if (b_dly > 0) begin
      b_dly <= b_dly - 1;
      b_qok <= (b_dly == 1);
    end
  end
  assign b_q = b_qok ? b_pend : ~b_pend;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic id, input logic [3:0] cnt);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    expq.push_back(e);
  endtask

  // Monitor: every accepted response must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && a_rv && a_rrdy) begin
      if (expq.size() == 0) begin
        checkOutput("resp_with_empty_queue", 32'(a_rv), 32'd0);
      end else begin
        monExp = expq.pop_front();
        checkOutput("resp_id", 32'(a_rid), 32'(monExp.id));
        checkOutput("resp_count", 32'(a_rc), 32'(monExp.cnt));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    a_r0v = 1'b0; a_r1v = 1'b0; b_r0v = 1'b0; b_r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expq.delete();
    lastServed = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic cycleA(output bit acc0, output bit acc1);
    @(negedge clk);
    acc0 = a_r0v && a_r0rdy;
    acc1 = a_r1v && a_r1rdy;
    @(posedge clk); #2;
    if (acc0) begin a_r0v = 1'b0; a_r0d = 8'($urandom); end
    if (acc1) begin a_r1v = 1'b0; a_r1d = 8'($urandom); end
  endtask

  task automatic drainA(input string name, input int limit);
    bit r0, r1;
    int cyc = 0;
    while ((a_r0v || a_r1v || a_busy || expq.size() != 0) && cyc < limit) begin
      cycleA(r0, r1);
      cyc++;
    end
    checkOutput(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  // One round: each selected requester offers one word; the model fixes the service order up front.
  task automatic applyStimulus(input bit use0, input bit use1, input logic [7:0] d0,
                               input logic [7:0] d1, input int stallPct);
    bit   p0, p1, r0, r1;
    int   n0 = 0, n1 = 0, cyc = 0;
    logic first;
    if (use0 && use1) begin
      first = ~lastServed;
      pushExp(first, refPop(first ? d1 : d0));
      pushExp(~first, refPop(first ? d0 : d1));
    end else if (use0) begin
      pushExp(1'b0, refPop(d0));
      lastServed = 1'b0;
    end else if (use1) begin
      pushExp(1'b1, refPop(d1));
      lastServed = 1'b1;
    end
    p0 = use0; p1 = use1;
    a_r0v = use0; a_r0d = d0;
    a_r1v = use1; a_r1d = d1;
    while ((p0 || p1 || expq.size() != 0) && cyc < 200) begin
      a_rrdy = ($urandom_range(99) >= stallPct);
      cycleA(r0, r1);
      if (r0) begin n0++; p0 = 1'b0; end
      if (r1) begin n1++; p1 = 1'b0; end
      cyc++;
    end
    checkOutput("round_accepts0", 32'(n0), 32'(use0));
    checkOutput("round_accepts1", 32'(n1), 32'(use1));
    checkOutput("round_drained", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    bit   r0, r1, prev0, prev1, u0, u1;
    int   accepts, cyc, acceptAt, rvAt, loads;

    rst_n = 1'b0;
    a_r0v = 1'b0; a_r1v = 1'b0; a_r0d = 8'h00; a_r1d = 8'h00; a_rrdy = 1'b0;
    b_r0v = 1'b0; b_r1v = 1'b0; b_r0d = 8'h00; b_r1d = 8'h00; b_rrdy = 1'b0;

    // Reset values before any clock edge: async reset alone must set them.
    #3;
    checkOutput("rst_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_resp_valid", 32'(a_rv), 32'd0);
    checkOutput("rst_resp_id", 32'(a_rid), 32'd0);
    checkOutput("rst_resp_count", 32'(a_rc), 32'd0);
    checkOutput("rst_unit_a", 32'(a_ua), 32'd0);
    checkOutput("rst_unit_load", 32'(a_load), 32'd0);
    checkOutput("rst_b_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;

    $display("[TB] UNIT_LAT=3 single request from requester 1");
    b_rrdy = 1'b1; b_r1d = 8'h00; b_r1v = 1'b1;
    acceptAt = -1; rvAt = -1; loads = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b_r1v && b_r1rdy && acceptAt < 0) acceptAt = n;
      if (b_load) loads++;
      if (b_rv && rvAt < 0) begin
        rvAt = n;
        checkOutput("b_resp_id", 32'(b_rid), 32'd1);
        checkOutput("b_resp_count", 32'(b_rc), 32'd0);
      end
      @(posedge clk); #2;
      if (acceptAt >= 0) b_r1v = 1'b0;
    end
    checkOutput("b_load_pulses", 32'(loads), 32'd1);
    checkOutput("b_latency", 32'(rvAt - acceptAt), 32'd5);

    $display("[TB] single request from requester 0");
    a_r0v = 1'b1; a_r0d = 8'hB2; a_rrdy = 1'b1;
    pushExp(1'b0, 4'd4); lastServed = 1'b0;
    @(negedge clk);
    checkOutput("t1_ready0", 32'(a_r0rdy), 32'd1);
    @(posedge clk); #2;
    a_r0v = 1'b0;
    @(negedge clk);
    checkOutput("t1_load", 32'(a_load), 32'd1);
    checkOutput("t1_unit_a", 32'(a_ua), 32'hB2);
    @(negedge clk);
    checkOutput("t1_load_pulse", 32'(a_load), 32'd0);
    checkOutput("t1_valid_early", 32'(a_rv), 32'd0);
    @(negedge clk);
    checkOutput("t1_resp_valid", 32'(a_rv), 32'd1);
    @(posedge clk); #2;
    drainA("t1_drained", 10);

    $display("[TB] both requesters valid continuously");
    doReset();
    a_r0v = 1'b1; a_r0d = 8'hFF; a_r1v = 1'b1; a_r1d = 8'h01; a_rrdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pushExp(~lastServed, lastServed ? 4'd8 : 4'd1);
      lastServed = ~lastServed;
    end
    accepts = 0; prev0 = 1'b0; prev1 = 1'b0; cyc = 0;
    while ((accepts < 4 || expq.size() != 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_r0rdy) checkOutput("t2_ready0_one_cycle", 32'(prev0), 32'd0);
      if (a_r1rdy) checkOutput("t2_ready1_one_cycle", 32'(prev1), 32'd0);
      prev0 = a_r0rdy; prev1 = a_r1rdy;
      if ((a_r0v && a_r0rdy) || (a_r1v && a_r1rdy)) accepts++;
      @(posedge clk); #2;
      if (accepts == 4) begin a_r0v = 1'b0; a_r1v = 1'b0; end
    end
    checkOutput("t2_accepts", 32'(accepts), 32'd4);
    checkOutput("t2_drained", 32'(expq.size()), 32'd0);
    expq.delete();

    $display("[TB] response backpressure");
    a_r1v = 1'b1; a_r1d = 8'h5A; a_rrdy = 1'b0;
    pushExp(1'b1, 4'd4); lastServed = 1'b1;
    for (int i = 0; i < 10 && !a_rv; i++) cycleA(r0, r1);
    checkOutput("t3_resp_valid", 32'(a_rv), 32'd1);
    a_r0v = 1'b1; a_r0d = 8'h0F;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t3_hold_valid", 32'(a_rv), 32'd1);
      checkOutput("t3_hold_id", 32'(a_rid), 32'd1);
      checkOutput("t3_hold_count", 32'(a_rc), 32'd4);
      checkOutput("t3_no_ready", 32'({a_r0rdy, a_r1rdy}), 32'd0);
      checkOutput("t3_busy", 32'(a_busy), 32'd1);
    end
    pushExp(1'b0, 4'd4); lastServed = 1'b0;
    @(posedge clk); #2;
    a_rrdy = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("t3_released", 32'(a_rv), 32'd0);
    checkOutput("t3_idle", 32'(a_busy), 32'd0);
    checkOutput("t3_next_ready0", 32'(a_r0rdy), 32'd1);
    @(posedge clk); #2;
    a_r0v = 1'b0;
    drainA("t3_drained", 20);

    $display("[TB] reset during WAIT");
    a_r0v = 1'b1; a_r0d = 8'h33; a_rrdy = 1'b1;
    cycleA(r0, r1);
    cycleA(r0, r1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_busy", 32'(a_busy), 32'd0);
    checkOutput("t4_resp_valid", 32'(a_rv), 32'd0);
    checkOutput("t4_unit_load", 32'(a_load), 32'd0);
    checkOutput("t4_unit_a", 32'(a_ua), 32'd0);
    checkOutput("t4_resp_count", 32'(a_rc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    expq.delete();
    lastServed = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    applyStimulus(1'b1, 1'b1, 8'h07, 8'h80, 0);

    $display("[TB] random rounds");
    for (int k = 0; k < 60; k++) begin
      u0 = 1'($urandom_range(1));
      u1 = 1'($urandom_range(1));
      if (!u0 && !u1) u0 = 1'b1;
      applyStimulus(u0, u1, 8'($urandom), 8'($urandom), 30);
    end

`ifdef POPCOUNT_SCHEDULER_CHECK_EN
    $display("[TB] self-check error flag");
    doReset();
    checkOutput("err_reset", 32'(a_err), 32'd0);
    corrupt_f0 = 1'b1;
    pushExp(1'b0, 4'd3); lastServed = 1'b0;
    a_r0v = 1'b1; a_r0d = 8'hF0; a_rrdy = 1'b1;
    drainA("err_drained", 20);
    checkOutput("err_set", 32'(a_err), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h0F, 0);
    checkOutput("err_sticky", 32'(a_err), 32'd1);
    corrupt_f0 = 1'b0;
    doReset();
    checkOutput("err_cleared", 32'(a_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
